// File: rtl/start_reset_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : start_reset_seq_pkg
//  Description : Shared state encoding and default timing for the FFT-core
//                start/reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package start_reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST       = 3'd1,
        ST_GAP       = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FIN       = 3'd5
    } seq_state_e;

    localparam int DEF_RST_CYCLES     = 2;
    localparam int DEF_GAP_CYCLES     = 1;
    localparam int DEF_START_CYCLES   = 1;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // Bits needed to hold the values 0 .. n-1 (at least one bit).
    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/start_reset_sequencer_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : Registered history of a level input and a one-cycle pulse
//                marking its rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig_q <= 1'b0;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    // Feeds only next-state logic, so no input-to-output path is created.
    assign o_rise = i_sig & ~r_sig_q;

endmodule
`default_nettype wire

// File: rtl/start_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : start_reset_sequencer
//  Description : Multi-frame reset/gap/start sequencer for the radix-4 FFT
//                core. Optional per-frame watchdog enabled by SEQ_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module start_reset_sequencer
    import start_reset_seq_pkg::*;
#(
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int START_CYCLES   = DEF_START_CYCLES,
    parameter int CNT_W          = 8,
    parameter int RUN_W          = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic [RUN_W-1:0] n_runs,
    input  logic             core_done,
    output logic             core_reset,
    output logic             core_start,
    output logic             busy,
    output logic             seq_done,
    output logic [RUN_W-1:0] runs_left,
    output logic             timeout
);

    localparam logic [2:0] c_IDLE  = 3'(ST_IDLE);
    localparam logic [2:0] c_RST   = 3'(ST_RST);
    localparam logic [2:0] c_GAP   = 3'(ST_GAP);
    localparam logic [2:0] c_START = 3'(ST_START);
    localparam logic [2:0] c_WAIT  = 3'(ST_WAIT_DONE);
    localparam logic [2:0] c_FIN   = 3'(ST_FIN);

    localparam logic [CNT_W-1:0] c_RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] c_START_LAST = CNT_W'(START_CYCLES - 1);
    localparam bit               c_NO_GAP     = (GAP_CYCLES == 0);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [RUN_W-1:0] r_runs_left;
    logic             w_trig_rise;
    logic             w_accept;
    logic             w_timed;
    logic             w_wdog_hit;

    rise_detect u_rise (
        .clk    (clk),
        .rst    (reset),
        .i_sig  (trigger),
        .o_rise (w_trig_rise)
    );

    // Edges outside IDLE are dropped, never queued.
    assign w_accept = (r_state == c_IDLE) && w_trig_rise;
    assign w_timed  = (r_state == c_RST) || (r_state == c_GAP) || (r_state == c_START);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) w_state_nxt = c_RST;
            end
            c_RST: begin
                if (r_cnt == c_RST_LAST) w_state_nxt = c_NO_GAP ? c_START : c_GAP;
            end
            c_GAP: begin
                if (r_cnt == c_GAP_LAST) w_state_nxt = c_START;
            end
            c_START: begin
                if (r_cnt == c_START_LAST) w_state_nxt = c_WAIT;
            end
            c_WAIT: begin
                if (core_done) begin
                    w_state_nxt = (r_runs_left != '0) ? c_START : c_FIN;
                end else if (w_wdog_hit) begin
                    w_state_nxt = c_FIN;
                end
            end
            c_FIN: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_timed) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Decrement on entry to START so the new count is visible with the pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_runs_left <= '0;
        end else if (w_accept) begin
            r_runs_left <= (n_runs == '0) ? RUN_W'(1) : n_runs;
        end else if ((w_state_nxt == c_START) && (r_state != c_START)) begin
            r_runs_left <= r_runs_left - RUN_W'(1);
        end else if (w_wdog_hit) begin
            r_runs_left <= '0;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int                  c_WDOG_W    = cnt_bits(TIMEOUT_CYCLES);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_timeout;

    // core_done in the expiry cycle wins over the watchdog.
    assign w_wdog_hit = (r_state == c_WAIT) && (r_wdog == c_WDOG_LAST) && !core_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wdog <= (r_state == c_WAIT) ? r_wdog + c_WDOG_W'(1) : '0;
            if (w_accept) begin
                r_timeout <= 1'b0;
            end else if (w_wdog_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_wdog_hit = 1'b0;
    assign timeout    = 1'b0;
`endif

    assign core_reset = (r_state == c_RST);
    assign core_start = (r_state == c_START);
    assign busy       = (r_state != c_IDLE);
    assign seq_done   = (r_state == c_FIN);
    assign runs_left  = r_runs_left;

endmodule
`default_nettype wire

// File: tb/tb_start_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_start_reset_sequencer
//  Description : Self-checking bench: vector table, directed corner cases and
//                randomized traffic against a frame-timeline reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_start_reset_sequencer;

    localparam int c_R  = 2;
    localparam int c_G  = 1;
    localparam int c_S  = 1;
    localparam int c_TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       trigger, core_done;
    logic [3:0] n_runs;
    logic       a_core_reset, a_core_start, a_busy, a_seq_done, a_timeout;
    logic [3:0] a_runs_left;
    logic       b_trigger, b_core_done;
    logic [3:0] b_n_runs;
    logic       b_core_reset, b_core_start, b_busy, b_seq_done, b_timeout;
    logic [3:0] b_runs_left;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    start_reset_sequencer #(.RST_CYCLES(c_R), .GAP_CYCLES(c_G), .START_CYCLES(c_S),
                            .CNT_W(8), .RUN_W(4), .TIMEOUT_CYCLES(c_TO)) u_dut_a (
        .clk(clk), .reset(reset), .trigger(trigger), .n_runs(n_runs), .core_done(core_done),
        .core_reset(a_core_reset), .core_start(a_core_start), .busy(a_busy),
        .seq_done(a_seq_done), .runs_left(a_runs_left), .timeout(a_timeout));

    start_reset_sequencer #(.RST_CYCLES(2), .GAP_CYCLES(0), .START_CYCLES(3),
                            .CNT_W(8), .RUN_W(4), .TIMEOUT_CYCLES(c_TO)) u_dut_b (
        .clk(clk), .reset(reset), .trigger(b_trigger), .n_runs(b_n_runs), .core_done(b_core_done),
        .core_reset(b_core_reset), .core_start(b_core_start), .busy(b_busy),
        .seq_done(b_seq_done), .runs_left(b_runs_left), .timeout(b_timeout));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each frame is a timeline measured from its origin.
    // The first frame carries a reset+gap prelude; restarts begin at the start pulse.
    bit m_active, m_fin, m_first, m_timeout, m_trig_q;
    int m_r, m_runs_left, m_wait_cnt;

    function automatic int m_prelude();
        return m_first ? c_R + c_G : 0;
    endfunction

    function automatic bit m_waiting();
        return m_active && !m_fin && (m_r > m_prelude() + c_S);
    endfunction

    task automatic model_reset();
        m_active = 0; m_fin = 0; m_first = 0; m_timeout = 0; m_trig_q = 0;
        m_r = 0; m_runs_left = 0; m_wait_cnt = 0;
    endtask

    task automatic model_step(input bit trig, input int nr, input bit done);
        bit edge_seen;
        int p;
        edge_seen = trig && !m_trig_q;
        m_trig_q  = trig;
        p         = m_prelude();
        if (!m_active) begin
            if (edge_seen) begin
                m_active = 1; m_fin = 0; m_first = 1; m_r = 1; m_timeout = 0;
                m_runs_left = (nr == 0) ? 1 : nr;
            end
        end else if (m_fin) begin
            m_active = 0; m_fin = 0;
        end else if (m_waiting()) begin
            if (done) begin
                if (m_runs_left != 0) begin
                    m_first = 0; m_r = 1; m_runs_left--;
                end else begin
                    m_fin = 1;
                end
            end
`ifdef SEQ_TIMEOUT_EN
            else if (m_wait_cnt == c_TO - 1) begin
                m_fin = 1; m_timeout = 1; m_runs_left = 0;
            end
`endif
            else begin
                m_wait_cnt++;
            end
        end else begin
            m_r++;
            if (m_r == p + 1) m_runs_left--;
            if (m_r > p + c_S) m_wait_cnt = 0;
        end
    endtask

    task automatic cmp_model(input string tag);
        int p;
        bit live;
        p    = m_prelude();
        live = m_active && !m_fin;
        check({tag, " core_reset"}, int'(a_core_reset), int'(live && m_first && m_r <= c_R));
        check({tag, " core_start"}, int'(a_core_start), int'(live && m_r > p && m_r <= p + c_S));
        check({tag, " busy"}, int'(a_busy), int'(m_active));
        check({tag, " seq_done"}, int'(a_seq_done), int'(m_fin));
        check({tag, " runs_left"}, int'(a_runs_left), m_runs_left);
        check({tag, " timeout"}, int'(a_timeout), int'(m_timeout));
        check({tag, " rst&start"}, int'(a_core_reset & a_core_start), 0);
    endtask

    bit cmp_en = 0;

    task automatic step();
        model_step(trigger, int'(n_runs), core_done);
        @(posedge clk);
        #1;
        if (cmp_en) cmp_model("model");
    endtask

    int rl_log[$];

    // Drives one sequence on DUT A, answering each start with core_done 3 cycles later.
    task automatic run_seq(input int nr, input bit retrig, output int starts,
                           output int resets, output int sdones);
        int  since;
        bit  ps, pr, fin;
        starts = 0; resets = 0; sdones = 0; since = 100; ps = 0; pr = 0; fin = 0;
        rl_log.delete();
        trigger = 1; n_runs = 4'(nr); core_done = 0;
        step();
        trigger = 0;
        for (int c = 0; c < 300 && !fin; c++) begin
            if (a_core_start && !ps) begin starts++; rl_log.push_back(int'(a_runs_left)); end
            if (a_core_reset && !pr) resets++;
            if (a_seq_done) begin sdones++; fin = 1; end
            ps = a_core_start; pr = a_core_reset;
            since = a_core_start ? 0 : since + 1;
            core_done = (since == 3);
            trigger = retrig && (since == 1);
            step();
        end
        core_done = 0; trigger = 0;
        if (!fin) check("run_seq bound", 0, 1);
    endtask

    typedef struct {
        bit       trig;
        bit [3:0] nr;
        bit       done;
        bit       e_rst, e_st, e_busy, e_sd;
        bit [3:0] e_rl;
    } vec_t;

    vec_t vt[19];

    initial begin
        int st, rs, sd;
        // trig nr done | reset start busy seq_done runs_left
        vt[0]  = '{1, 1, 0, 1, 0, 1, 0, 1};
        vt[1]  = '{1, 1, 0, 1, 0, 1, 0, 1};
        vt[2]  = '{0, 1, 0, 0, 0, 1, 0, 1};
        vt[3]  = '{0, 1, 0, 0, 1, 1, 0, 0};
        for (int i = 4; i <= 8; i++) vt[i] = '{0, 1, 0, 0, 0, 1, 0, 0};
        vt[9]  = '{0, 1, 1, 0, 0, 1, 1, 0};
        vt[10] = '{0, 1, 0, 0, 0, 0, 0, 0};
        vt[11] = '{0, 1, 1, 0, 0, 0, 0, 0};
        vt[12] = '{1, 0, 0, 1, 0, 1, 0, 1};
        vt[13] = '{1, 0, 0, 1, 0, 1, 0, 1};
        vt[14] = '{0, 0, 1, 0, 0, 1, 0, 1};
        vt[15] = '{0, 0, 1, 0, 1, 1, 0, 0};
        vt[16] = '{0, 0, 1, 0, 0, 1, 0, 0};
        vt[17] = '{0, 0, 1, 0, 0, 1, 1, 0};
        vt[18] = '{0, 0, 0, 0, 0, 0, 0, 0};

        reset = 1; trigger = 0; n_runs = 0; core_done = 0;
        b_trigger = 0; b_n_runs = 1; b_core_done = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset core_reset", int'(a_core_reset), 0);
        check("reset core_start", int'(a_core_start), 0);
        check("reset busy", int'(a_busy), 0);
        check("reset seq_done", int'(a_seq_done), 0);
        check("reset runs_left", int'(a_runs_left), 0);
        check("reset timeout", int'(a_timeout), 0);
        reset = 0;
        step();

        // Vector table on DUT A
        for (int i = 0; i < 19; i++) begin
            trigger = vt[i].trig; n_runs = vt[i].nr; core_done = vt[i].done;
            step();
            check($sformatf("vec%0d core_reset", i), int'(a_core_reset), int'(vt[i].e_rst));
            check($sformatf("vec%0d core_start", i), int'(a_core_start), int'(vt[i].e_st));
            check($sformatf("vec%0d busy", i), int'(a_busy), int'(vt[i].e_busy));
            check($sformatf("vec%0d seq_done", i), int'(a_seq_done), int'(vt[i].e_sd));
            check($sformatf("vec%0d runs_left", i), int'(a_runs_left), int'(vt[i].e_rl));
        end
        trigger = 0; core_done = 0;
        cmp_en = 1;
        step();

        // Three frames, with re-trigger pulses while waiting
        run_seq(3, 1, st, rs, sd);
        check("n3 starts", st, 3);
        check("n3 resets", rs, 1);
        check("n3 seq_done", sd, 1);
        check("n3 log size", rl_log.size(), 3);
        for (int i = 0; i < rl_log.size() && i < 3; i++)
            check($sformatf("n3 runs_left[%0d]", i), rl_log[i], 2 - i);
        repeat (3) step();

        // GAP_CYCLES=0, START_CYCLES=3 on DUT B
        b_trigger = 1;
        for (int i = 1; i <= 8; i++) begin
            step();
            b_trigger = 0;
            check($sformatf("g0 core_reset c%0d", i), int'(b_core_reset), int'(i <= 2));
            check($sformatf("g0 core_start c%0d", i), int'(b_core_start), int'(i >= 3 && i <= 5));
            check($sformatf("g0 busy c%0d", i), int'(b_busy), 1);
        end
        b_core_done = 1;
        step();
        b_core_done = 0;
        check("g0 seq_done", int'(b_seq_done), 1);
        step();
        check("g0 idle busy", int'(b_busy), 0);

        // Asynchronous reset in the middle of START
        trigger = 1; n_runs = 2;
        step();
        trigger = 0;
        for (int c = 0; c < 20 && !a_core_start; c++) step();
        check("pre-reset core_start", int'(a_core_start), 1);
        #2 reset = 1;
        #1;
        check("async core_start", int'(a_core_start), 0);
        check("async busy", int'(a_busy), 0);
        check("async runs_left", int'(a_runs_left), 0);
        model_reset();
        @(posedge clk);
        #1 reset = 0;
        step();
        run_seq(1, 0, st, rs, sd);
        check("post-reset starts", st, 1);
        check("post-reset resets", rs, 1);
        check("post-reset seq_done", sd, 1);
        step();

`ifdef SEQ_TIMEOUT_EN
        // No core_done: watchdog ends the sequence, next trigger clears the flag
        trigger = 1; n_runs = 3;
        step();
        trigger = 0;
        for (int c = 0; c < 60 && !a_seq_done; c++) step();
        check("wd seq_done", int'(a_seq_done), 1);
        check("wd timeout", int'(a_timeout), 1);
        check("wd runs_left", int'(a_runs_left), 0);
        step();
        trigger = 1;
        step();
        trigger = 0;
        check("wd cleared", int'(a_timeout), 0);
        for (int c = 0; c < 60 && !a_seq_done; c++) step();
        step();
`endif

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 5) == 0) trigger = ~trigger;
            n_runs    = 4'($urandom_range(0, 3));
            core_done = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
